// File: rtl/inv_mixcolumn_seq.sv
// Iterative AES InvMixColumns: accepts a 128-bit state, transforms one column per
// clock over four cycles, then holds the result on a valid/ready output handshake.
module inv_mixcolumn_seq (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         invmix_valid_i,
    output logic         invmix_ready_o,
    input  logic [127:0] invmix_i,
    output logic         invmix_valid_o,
    input  logic         invmix_ready_i,
    output logic [127:0] invmix_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   col_cnt;
    logic [127:0] work;
    logic [31:0]  col_in, col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse-matrix coefficients built from the x2/x4/x8 chain of each byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            s[r]  = col[8*(3-r) +: 8];
            x2    = xtime(s[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ s[r];
            mb[r] = x8 ^ x2 ^ s[r];
            md[r] = x8 ^ x4 ^ s[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Row r of column c lives at byte index 4*(3-r)+c; gather row 0 first.
    always_comb begin
        col_in = '0;
        for (int r = 0; r < 4; r++)
            col_in[8*(3-r) +: 8] = work[8*(4*(3-r) + int'(col_cnt)) +: 8];
    end

    assign col_out = inv_mix_col(col_in);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (invmix_valid_i) state_nxt = BUSY;
            BUSY:    if (col_cnt == 2'd3) state_nxt = DONE;
            DONE:    if (invmix_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work    <= '0;
            col_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: if (invmix_valid_i) begin
                    work    <= invmix_i;
                    col_cnt <= 2'd0;
                end
                BUSY: begin
                    for (int r = 0; r < 4; r++)
                        work[8*(4*(3-r) + int'(col_cnt)) +: 8] <= col_out[8*(3-r) +: 8];
                    col_cnt <= col_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output is the working register itself; only valid_o qualifies it.
    assign invmix_ready_o = (state == IDLE);
    assign invmix_valid_o = (state == DONE);
    assign invmix_o       = work;

endmodule

// File: tb/tb_inv_mixcolumn_seq.sv
// Randomized self-checking bench for inv_mixcolumn_seq against a GF(2^8) matrix model.
module tb_inv_mixcolumn_seq;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         invmix_valid_i;
    logic         invmix_ready_o;
    logic [127:0] invmix_i;
    logic         invmix_valid_o;
    logic         invmix_ready_i;
    logic [127:0] invmix_o;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [127:0] VEC_IN  = 128'hd5c69f8e_d5c6dc4d_d7c658a1_d6c69dbc;
    localparam logic [127:0] VEC_OUT = 128'hd4c6f2db_d4c60a13_d4c62253_d5c65c45;

    inv_mixcolumn_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .invmix_valid_i (invmix_valid_i),
        .invmix_ready_o (invmix_ready_o),
        .invmix_i       (invmix_i),
        .invmix_valid_o (invmix_valid_o),
        .invmix_ready_i (invmix_ready_i),
        .invmix_o       (invmix_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Shift-and-add GF(2^8) product, reduced by the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    // Circulant matrix product over every column; inv selects InvMixColumns.
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) begin
            base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
        end else begin
            base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(base[(j - i + 4) % 4], s[8*(4*(3-j)+c) +: 8]);
                o[8*(4*(3-i)+c) +: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full transaction with ready_i high: checks 4-cycle latency and 1-cycle valid pulse.
    task automatic run_txn(input logic [127:0] din, output logic [127:0] dout);
        int w;
        int lat;
        invmix_ready_i = 1'b1;
        invmix_valid_i = 1'b1;
        invmix_i       = din;
        w = 0;
        while (!invmix_ready_o && w < 20) begin
            tick();
            w++;
        end
        chk("accept_wait", 128'(invmix_ready_o), 128'd1);
        tick();
        invmix_valid_i = 1'b0;
        invmix_i       = rand128();
        lat = 0;
        while (!invmix_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 128'(lat), 128'd4);
        dout = invmix_o;
        tick();
        chk("valid_pulse", 128'(invmix_valid_o), 128'd0);
        chk("ready_back", 128'(invmix_ready_o), 128'd1);
    endtask

    initial begin
        logic [127:0] res, orig, held;
        logic [127:0] exp_q[$];
        int last_acc, n_acc, w;

        rst_i          = 1'b1;
        invmix_valid_i = 1'b0;
        invmix_ready_i = 1'b1;
        invmix_i       = '0;
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_ready", 128'(invmix_ready_o), 128'd1);
        chk("rst_valid", 128'(invmix_valid_o), 128'd0);
        chk("rst_data", invmix_o, 128'h0);

        // Known-answer vector, also cross-checked against the model.
        chk("model_kat", mix(VEC_IN, 1'b1), VEC_OUT);
        run_txn(VEC_IN, res);
        chk("fips_kat", res, VEC_OUT);

        // Output stall with a competing input that must be ignored.
        invmix_ready_i = 1'b0;
        invmix_valid_i = 1'b1;
        invmix_i       = VEC_IN;
        tick();
        invmix_i = ~VEC_IN;
        w = 0;
        while (!invmix_valid_o && w < 20) begin
            tick();
            w++;
        end
        chk("stall_valid_rise", 128'(invmix_valid_o), 128'd1);
        held = invmix_o;
        chk("stall_data", held, VEC_OUT);
        for (int i = 0; i < 10; i++) begin
            invmix_i = rand128();
            tick();
            chk("stall_hold_valid", 128'(invmix_valid_o), 128'd1);
            chk("stall_hold_data", invmix_o, held);
            chk("stall_ready_low", 128'(invmix_ready_o), 128'd0);
        end
        invmix_valid_i = 1'b0;
        invmix_ready_i = 1'b1;
        tick();
        chk("stall_release_ready", 128'(invmix_ready_o), 128'd1);
        chk("stall_release_valid", 128'(invmix_valid_o), 128'd0);

        // Round trip through the forward model, plus the constant corner states.
        for (int n = 0; n < 200; n++) begin
            orig = rand128();
            run_txn(mix(orig, 1'b0), res);
            chk("round_trip", res, orig);
        end
        run_txn(128'h0, res);
        chk("all_zero", res, 128'h0);
        run_txn({128{1'b1}}, res);
        chk("all_ff", res, {128{1'b1}});

        // Reset one cycle after column 1 lands; partial result must vanish.
        invmix_valid_i = 1'b1;
        invmix_i       = rand128();
        tick();
        invmix_valid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_ready", 128'(invmix_ready_o), 128'd1);
        chk("midrst_valid", 128'(invmix_valid_o), 128'd0);
        chk("midrst_data", invmix_o, 128'h0);
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (invmix_valid_o) n_acc++;
            tick();
        end
        chk("midrst_no_pulse", 128'(n_acc), 128'd0);
        orig = rand128();
        run_txn(orig, res);
        chk("midrst_fresh", res, mix(orig, 1'b1));

        // Valid held high: one accept per 6 cycles, mid-BUSY input changes ignored.
        invmix_ready_i = 1'b1;
        invmix_valid_i = 1'b1;
        last_acc = -1;
        n_acc    = 0;
        for (int cyc = 0; cyc < 42; cyc++) begin
            if (invmix_valid_o) begin
                if (exp_q.size() > 0) chk("held_data", invmix_o, exp_q.pop_front());
                else chk("held_extra_output", 128'(invmix_valid_o), 128'd0);
            end
            if (cyc >= 37) invmix_valid_i = 1'b0;
            invmix_i = rand128();
            if (invmix_valid_i && invmix_ready_o) begin
                exp_q.push_back(mix(invmix_i, 1'b1));
                if (last_acc >= 0) chk("held_spacing", 128'(cyc - last_acc), 128'd6);
                last_acc = cyc;
                n_acc++;
            end
            tick();
        end
        chk("held_accepts", 128'(n_acc), 128'd7);
        chk("held_drain", 128'(exp_q.size()), 128'd0);
        chk("held_idle", 128'(invmix_ready_o), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
